sdram_dma_writer: RTL and testbench

- Streams 128-bit words from the upstream line-data FIFO into HPS SDRAM over the Avalon-MM write port (SDRAM0_*).
- Uses buffer commands (start address, size) issued by software through the CTRL_REG dma_on bit, DMA_ADR_EXPORT and DMA_BUF_SIZE_EXPORT.
- Reports completed buffers on DMA_STATUS_EXPORT so the Linux driver can recycle command slots.
- Sits between the CIS line packer FIFO and the HPS F2S SDRAM bridge.

---
 rtl/sdram_dma_writer.sv | 180 ++++++++++++++++++
 tb/tb_sdram_dma_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dma_writer.sv
// sdram_dma_writer: queues software buffer commands and streams 128-bit words
// from a show-ahead line FIFO into the HPS SDRAM Avalon-MM write port.
module sdram_dma_writer #(
   parameter int CMD_FIFO_DEPTH = 4,
   parameter int ADR_W          = 28,
   parameter int DATA_W         = 128
) (
   input  logic              CLK_80,
   input  logic              RESET,
   input  logic              DMA_START,
   input  logic [ADR_W-1:0]  DMA_ADR,
   input  logic [ADR_W-1:0]  DMA_BUF_SIZE,
   output logic [31:0]       DMA_STATUS,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              DATA_EMPTY,
   output logic              DATA_RD,
   output logic [ADR_W-1:0]  SDRAM0_ADDRESS,
   output logic [DATA_W-1:0] SDRAM0_WRITEDATA,
   output logic              SDRAM0_WRITE,
   input  logic              SDRAM0_WAITREQUEST
);
   localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // command FIFO storage and control
   logic [ADR_W-1:0] cmd_adr_q  [CMD_FIFO_DEPTH];
   logic [ADR_W-1:0] cmd_size_q [CMD_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cmd_cnt_q;
   logic             ovf_q;
   logic             push, pop, full;

   // datapath / FSM registers
   state_t            state_q, state_d;
   logic [ADR_W-1:0]  cur_adr_q, cur_adr_d;
   logic [ADR_W-1:0]  remain_q, remain_d;
   logic [ADR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [15:0]       done_cnt_q, done_cnt_d;
   logic              rd;
   logic              busy;

   assign full = (cmd_cnt_q == DEPTH_C);
   assign push = DMA_START & ~full;

   // command storage: written only on an accepted push, needs no reset
   always_ff @(posedge CLK_80) begin
      if (push) begin
         cmd_adr_q[wr_ptr_q]  <= DMA_ADR;
         cmd_size_q[wr_ptr_q] <= DMA_BUF_SIZE;
      end
   end

   // command FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge CLK_80) begin
      if (RESET) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cmd_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
            2'b01:   cmd_cnt_q <= cmd_cnt_q - CNT_W'(1);
            default: cmd_cnt_q <= cmd_cnt_q;
         endcase
         if (DMA_START && full) ovf_q <= 1'b1;
      end
   end

   // FSM state and Avalon output registers
   always_ff @(posedge CLK_80) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         cur_adr_q  <= '0;
         remain_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         done_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         cur_adr_q  <= cur_adr_d;
         remain_q   <= remain_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         write_q    <= write_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   // next-state logic: command pop, word presentation, accept handling
   always_comb begin
      state_d    = state_q;
      cur_adr_d  = cur_adr_q;
      remain_d   = remain_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = write_q;
      done_cnt_d = done_cnt_q;
      pop        = 1'b0;
      rd         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_cnt_q != '0) begin
               pop       = 1'b1;
               cur_adr_d = cmd_adr_q[rd_ptr_q];
               remain_d  = cmd_size_q[rd_ptr_q];
               state_d   = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (remain_q == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!write_q) begin
               // bus idle: present the FIFO head as soon as it exists
               if (!DATA_EMPTY) begin
                  rd      = 1'b1;
                  write_d = 1'b1;
                  addr_d  = cur_adr_q;
                  wdata_d = DATA_IN;
               end else begin
                  write_d = 1'b0;
               end
            end else if (!SDRAM0_WAITREQUEST) begin
               // word accepted: advance, then chain the next word if available
               cur_adr_d = cur_adr_q + ADR_W'(1);
               remain_d  = remain_q - ADR_W'(1);
               if (remain_q == ADR_W'(1)) begin
                  write_d = 1'b0;
                  state_d = S_DONE;
               end else if (!DATA_EMPTY) begin
                  rd      = 1'b1;
                  write_d = 1'b1;
                  addr_d  = cur_adr_q + ADR_W'(1);
                  wdata_d = DATA_IN;
               end else begin
                  write_d = 1'b0;
               end
            end else begin
               // stalled: hold address, data and request
               write_d = 1'b1;
            end
         end
         S_DONE: begin
            done_cnt_d = done_cnt_q + 16'd1;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy             = (state_q != S_IDLE) | (cmd_cnt_q != '0);
   assign DATA_RD          = rd & ~RESET;
   assign SDRAM0_ADDRESS   = addr_q;
   assign SDRAM0_WRITEDATA = wdata_q;
   assign SDRAM0_WRITE     = write_q;
   assign DMA_STATUS       = {14'd0, ovf_q, busy, done_cnt_q};

endmodule

// File: tb/tb_sdram_dma_writer.sv
// tb_sdram_dma_writer: directed sequence with an upstream FIFO model, an
// Avalon slave model and an address/data scoreboard.
module tb_sdram_dma_writer;
   logic         CLK_80 = 1'b0;
   logic         RESET;
   logic         DMA_START;
   logic [27:0]  DMA_ADR;
   logic [27:0]  DMA_BUF_SIZE;
   logic [31:0]  DMA_STATUS;
   logic [127:0] DATA_IN;
   logic         DATA_EMPTY;
   logic         DATA_RD;
   logic [27:0]  SDRAM0_ADDRESS;
   logic [127:0] SDRAM0_WRITEDATA;
   logic         SDRAM0_WRITE;
   logic         SDRAM0_WAITREQUEST;

   int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;
   int rd_cnt = 0, acc_cnt = 0, wr_cycles = 0;
   logic [27:0]  addr_972;
   logic [15:0]  pix = 16'd0;
   bit stall_mode = 1'b0, stall_hold = 1'b0, starve_mode = 1'b0;

   logic [127:0] fifo_q[$];
   logic [127:0] exp_data_q[$];
   logic [27:0]  exp_addr_q[$];

   sdram_dma_writer dut (
      .CLK_80(CLK_80), .RESET(RESET), .DMA_START(DMA_START), .DMA_ADR(DMA_ADR),
      .DMA_BUF_SIZE(DMA_BUF_SIZE), .DMA_STATUS(DMA_STATUS), .DATA_IN(DATA_IN),
      .DATA_EMPTY(DATA_EMPTY), .DATA_RD(DATA_RD), .SDRAM0_ADDRESS(SDRAM0_ADDRESS),
      .SDRAM0_WRITEDATA(SDRAM0_WRITEDATA), .SDRAM0_WRITE(SDRAM0_WRITE),
      .SDRAM0_WAITREQUEST(SDRAM0_WAITREQUEST)
   );

   initial forever #5 CLK_80 = ~CLK_80;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic tick();
      @(posedge CLK_80);
      #1;
   endtask

   // continuous 16-bit pixel ramp, eight pixels per word, lowest pixel in bits [15:0]
   task automatic load_ramp(input int n);
      logic [127:0] w;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 8; i++) begin
            w[16*i +: 16] = pix;
            pix = pix + 16'd1;
         end
         fifo_q.push_back(w);
         exp_data_q.push_back(w);
      end
   endtask

   task automatic start_cmd(input logic [27:0] adr, input logic [27:0] size, input bit accept);
      DMA_ADR = adr;
      DMA_BUF_SIZE = size;
      DMA_START = 1'b1;
      tick();
      DMA_START = 1'b0;
      if (accept)
         for (int k = 0; k < int'(size); k++) exp_addr_q.push_back(adr + 28'(k));
      tick();
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      tick();
      @(negedge CLK_80);
      while (DMA_STATUS[16] && n < budget) begin
         @(negedge CLK_80);
         n++;
      end
      chk({tag, "_timeout"}, 128'(n < budget), 128'(1'b1));
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      stall_mode = 1'b0; stall_hold = 1'b0; starve_mode = 1'b0;
      tick(); tick();
      fifo_q.delete(); exp_data_q.delete(); exp_addr_q.delete();
      @(negedge CLK_80);
      chk("rst_write", 128'(SDRAM0_WRITE), 128'(1'b0));
      chk("rst_addr", 128'(SDRAM0_ADDRESS), 128'(28'd0));
      chk("rst_wdata", SDRAM0_WRITEDATA, 128'd0);
      chk("rst_status", 128'(DMA_STATUS), 128'(32'd0));
      tick();
      RESET = 1'b0;
      tick();
   endtask

   task automatic sb_empty(input string tag);
      chk({tag, "_addr_left"}, 128'(exp_addr_q.size()), 128'(0));
      chk({tag, "_data_left"}, 128'(exp_data_q.size()), 128'(0));
   endtask

   // bus monitor + upstream FIFO model + Avalon slave model
   initial begin : mon
      bit prev_hold = 1'b0, prev_write = 1'b0, rd_now, write_now;
      logic [27:0]  prev_addr;
      logic [127:0] prev_data;
      logic [15:0]  prev_cnt = 16'd0;
      int stall_cnt = 0;
      bit starve;
      forever begin
         @(negedge CLK_80);
         if (!RESET) begin
            if (DATA_RD) begin
               rd_cnt++;
               chk("rd_not_empty", 128'(DATA_EMPTY), 128'(1'b0));
            end
            if (SDRAM0_WRITE) wr_cycles++;
            if (prev_hold) begin
               chk("stall_addr", 128'({SDRAM0_WRITE, SDRAM0_ADDRESS}), 128'({1'b1, prev_addr}));
               chk("stall_data", SDRAM0_WRITEDATA, prev_data);
            end
            if (SDRAM0_WRITE && !SDRAM0_WAITREQUEST) begin
               if (acc_cnt == 972) addr_972 = SDRAM0_ADDRESS;
               acc_cnt++;
               chk("sb_avail", 128'(exp_addr_q.size() != 0 && exp_data_q.size() != 0), 128'(1'b1));
               if (exp_addr_q.size() != 0 && exp_data_q.size() != 0) begin
                  chk("wr_addr", 128'(SDRAM0_ADDRESS), 128'(exp_addr_q.pop_front()));
                  chk("wr_data", SDRAM0_WRITEDATA, exp_data_q.pop_front());
               end
            end
            if (DMA_STATUS[15:0] !== prev_cnt)
               chk("count_step", 128'(DMA_STATUS[15:0]), 128'(prev_cnt + 16'd1));
         end
         prev_hold = !RESET && SDRAM0_WRITE && SDRAM0_WAITREQUEST;
         prev_addr = SDRAM0_ADDRESS;
         prev_data = SDRAM0_WRITEDATA;
         prev_cnt  = DMA_STATUS[15:0];
         rd_now    = DATA_RD && !RESET;
         write_now = SDRAM0_WRITE && !RESET;
         @(posedge CLK_80);
         #1;
         if (rd_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
         // a fresh write request opens a long stall window
         if (stall_mode && write_now && !prev_write) stall_cnt = $urandom_range(10, 150);
         prev_write = write_now;
         SDRAM0_WAITREQUEST = stall_hold || (stall_cnt > 0) ||
                              (stall_mode && $urandom_range(0, 3) == 0);
         if (stall_cnt > 0) stall_cnt--;
         starve = starve_mode && ($urandom_range(0, 7) == 0);
         DATA_EMPTY = (fifo_q.size() == 0) || starve;
         DATA_IN = (fifo_q.size() != 0) ? fifo_q[0] : 128'd0;
      end
   end

   initial begin : main
      int n;
      bit seen;
      RESET = 1'b1; DMA_START = 1'b0; DMA_ADR = 28'd0; DMA_BUF_SIZE = 28'd0;
      DATA_IN = 128'd0; DATA_EMPTY = 1'b1; SDRAM0_WAITREQUEST = 1'b0;
      do_reset();

      // one full line, no stalls
      rd_cnt = 0; acc_cnt = 0;
      load_ramp(972);
      start_cmd(28'd0, 28'd972, 1'b1);
      wait_idle("t1", 5000);
      chk("t1_status", 128'(DMA_STATUS), 128'(32'h0000_0001));
      chk("t1_acc", 128'(acc_cnt), 128'(972));
      chk("t1_rd", 128'(rd_cnt), 128'(972));
      sb_empty("t1");

      // random slave stalls; starvation gaps create fresh write rising edges
      do_reset();
      rd_cnt = 0; acc_cnt = 0;
      stall_mode = 1'b1; starve_mode = 1'b1;
      load_ramp(972);
      start_cmd(28'd0, 28'd972, 1'b1);
      wait_idle("t2", 40000);
      chk("t2_status", 128'(DMA_STATUS), 128'(32'h0000_0001));
      chk("t2_rd", 128'(rd_cnt), 128'(972));
      chk("t2_acc", 128'(acc_cnt), 128'(972));
      sb_empty("t2");

      // three queued commands with FIFO starvation
      do_reset();
      rd_cnt = 0; acc_cnt = 0;
      starve_mode = 1'b1;
      load_ramp(2916);
      start_cmd(28'd0, 28'd972, 1'b1);
      start_cmd(28'd2916, 28'd972, 1'b1);
      start_cmd(28'd5832, 28'd972, 1'b1);
      wait_idle("t3", 20000);
      chk("t3_status", 128'(DMA_STATUS), 128'(32'h0000_0003));
      chk("t3_buf2_first", 128'(addr_972), 128'(28'd2916));
      chk("t3_acc", 128'(acc_cnt), 128'(2916));
      sb_empty("t3");

      // zero-length buffer: completes with no bus traffic
      do_reset();
      rd_cnt = 0; acc_cnt = 0; wr_cycles = 0;
      load_ramp(2);
      start_cmd(28'd50, 28'd0, 1'b1);
      wait_idle("t4", 100);
      chk("t4_status", 128'(DMA_STATUS), 128'(32'h0000_0001));
      chk("t4_no_write", 128'(wr_cycles), 128'(0));
      chk("t4_no_rd", 128'(rd_cnt), 128'(0));

      // five commands while the engine is stuck on a stalled buffer
      stall_hold = 1'b1;
      load_ramp(12);
      start_cmd(28'd100, 28'd2, 1'b1);
      tick(); tick();
      for (int k = 0; k < 5; k++) start_cmd(28'd200 + 28'(10*k), 28'd3, k < 4);
      @(negedge CLK_80);
      chk("t5_ovf", 128'(DMA_STATUS[17]), 128'(1'b1));
      chk("t5_busy", 128'(DMA_STATUS[16]), 128'(1'b1));
      tick();
      stall_hold = 1'b0;
      wait_idle("t5", 500);
      chk("t5_status", 128'(DMA_STATUS), 128'(32'h0002_0006));
      chk("t5_rd", 128'(rd_cnt), 128'(14));
      sb_empty("t5");

      // reset while a write is stalled mid-buffer
      rd_cnt = 0; acc_cnt = 0;
      load_ramp(972);
      start_cmd(28'd0, 28'd972, 1'b1);
      n = 0;
      while (acc_cnt < 100 && n < 5000) begin tick(); n++; end
      chk("t6_reach100", 128'(acc_cnt >= 100), 128'(1'b1));
      stall_hold = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < 50) begin
         @(negedge CLK_80);
         seen = SDRAM0_WRITE && SDRAM0_WAITREQUEST;
         n++;
      end
      chk("t6_stalled", 128'(seen), 128'(1'b1));
      tick();
      RESET = 1'b1;
      tick();
      @(negedge CLK_80);
      chk("t6_write_drop", 128'(SDRAM0_WRITE), 128'(1'b0));
      chk("t6_status", 128'(DMA_STATUS), 128'(32'd0));
      stall_hold = 1'b0;
      fifo_q.delete(); exp_data_q.delete(); exp_addr_q.delete();
      tick();
      RESET = 1'b0;
      tick();
      acc_cnt = 0;
      load_ramp(972);
      start_cmd(28'd0, 28'd972, 1'b1);
      wait_idle("t6", 5000);
      chk("t6_final_status", 128'(DMA_STATUS), 128'(32'h0000_0001));
      chk("t6_acc", 128'(acc_cnt), 128'(972));
      sb_empty("t6");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
